// File: rtl/reg_out_tx.sv
// rtl/reg_out_tx.sv - OUT-instruction register capture and 8N1 UART transmitter with one-entry holding buffer
module reg_out_tx #(
    parameter int CLKS_PER_BIT = 87
) (
    input  logic       clock,
    input  logic       reset,
    input  logic       ena,
    input  logic [2:0] opcode,
    input  logic [7:0] R0_in,
    input  logic [7:0] R1_in,
    output logic       tx,
    output logic       busy,
    output logic       overrun,
    output logic [7:0] tx_count
);

    // Baud counter is just wide enough to hold CLKS_PER_BIT-1.
    localparam int BW = (CLKS_PER_BIT > 2) ? $clog2(CLKS_PER_BIT) : 1;
    localparam logic [BW-1:0] BAUD_LAST = BW'(CLKS_PER_BIT - 1);

    typedef enum logic [1:0] {
        S_IDLE,
        S_START,
        S_DATA,
        S_STOP
    } state_t;

    state_t          state_q, state_d;
    logic [BW-1:0]   baud_q, baud_d;
    logic [2:0]      bit_q, bit_d;
    logic [7:0]      shift_q, shift_d;
    logic            tx_q, tx_d;
    logic [7:0]      buf_q, buf_d;
    logic            buf_full_q, buf_full_d;
    logic            overrun_q, overrun_d;
    logic [7:0]      count_q, count_d;

    logic            req;
    logic [7:0]      req_byte;
    logic            baud_done;
    logic            frame_end;

    // Request decode: only OUT R0 / OUT R1 while the instruction strobe is high.
    always_comb begin
        req       = ena & ((opcode == 3'b100) | (opcode == 3'b101));
        req_byte  = opcode[0] ? R1_in : R0_in;
        baud_done = (baud_q == BAUD_LAST);
        frame_end = (state_q == S_STOP) & baud_done;
    end

    // State and datapath registers; reset aborts any frame immediately with tx high.
    always_ff @(posedge clock or negedge reset) begin
        if (!reset) begin
            state_q    <= S_IDLE;
            baud_q     <= '0;
            bit_q      <= 3'd0;
            shift_q    <= 8'h00;
            tx_q       <= 1'b1;
            buf_q      <= 8'h00;
            buf_full_q <= 1'b0;
            overrun_q  <= 1'b0;
            count_q    <= 8'h00;
        end else begin
            state_q    <= state_d;
            baud_q     <= baud_d;
            bit_q      <= bit_d;
            shift_q    <= shift_d;
            tx_q       <= tx_d;
            buf_q      <= buf_d;
            buf_full_q <= buf_full_d;
            overrun_q  <= overrun_d;
            count_q    <= count_d;
        end
    end

    // Next-state logic: frame sequencing, serial bit selection and holding-buffer management.
    always_comb begin
        state_d    = state_q;
        baud_d     = baud_q + BW'(1);
        bit_d      = bit_q;
        shift_d    = shift_q;
        tx_d       = tx_q;
        buf_d      = buf_q;
        buf_full_d = buf_full_q;
        overrun_d  = overrun_q;
        count_d    = count_q;

        case (state_q)
            S_IDLE: begin
                baud_d = '0;
                bit_d  = 3'd0;
                tx_d   = 1'b1;
                if (req) begin
                    shift_d = req_byte;
                    tx_d    = 1'b0;
                    state_d = S_START;
                end
            end
            S_START: begin
                if (baud_done) begin
                    baud_d  = '0;
                    bit_d   = 3'd0;
                    tx_d    = shift_q[0];
                    shift_d = {1'b0, shift_q[7:1]};
                    state_d = S_DATA;
                end
            end
            S_DATA: begin
                if (baud_done) begin
                    baud_d = '0;
                    if (bit_q == 3'd7) begin
                        tx_d    = 1'b1;
                        state_d = S_STOP;
                    end else begin
                        tx_d    = shift_q[0];
                        shift_d = {1'b0, shift_q[7:1]};
                        bit_d   = bit_q + 3'd1;
                    end
                end
            end
            S_STOP: begin
                if (baud_done) begin
                    baud_d  = '0;
                    count_d = count_q + 8'd1;
                    if (buf_full_q) begin
                        shift_d = buf_q;
                        tx_d    = 1'b0;
                        state_d = S_START;
                    end else if (req) begin
                        shift_d = req_byte;
                        tx_d    = 1'b0;
                        state_d = S_START;
                    end else begin
                        state_d = S_IDLE;
                    end
                end
            end
            default: begin
                state_d = S_IDLE;
                tx_d    = 1'b1;
            end
        endcase

        // While a frame is in flight, requests go to the buffer; at frame end a full
        // buffer drains into the shifter and the new request can refill it in the same cycle.
        if (state_q != S_IDLE) begin
            if (frame_end) begin
                if (buf_full_q) begin
                    buf_full_d = req;
                    if (req) begin
                        buf_d = req_byte;
                    end
                end
            end else if (req) begin
                if (!buf_full_q) begin
                    buf_d      = req_byte;
                    buf_full_d = 1'b1;
                end else begin
                    overrun_d  = 1'b1;
                end
            end
        end
    end

    // Outputs come straight from registers.
    always_comb begin
        tx       = tx_q;
        busy     = (state_q != S_IDLE) | buf_full_q;
        overrun  = overrun_q;
        tx_count = count_q;
    end

endmodule

// File: tb/tb_reg_out_tx.sv
// tb/tb_reg_out_tx.sv - self-checking bench for reg_out_tx against a frame-level reference model
module tb_reg_out_tx;

    localparam int CPB = 4;

    logic       clock  = 1'b0;
    logic       reset  = 1'b0;
    logic       ena    = 1'b0;
    logic [2:0] opcode = 3'd0;
    logic [7:0] R0_in  = 8'h00;
    logic [7:0] R1_in  = 8'h00;
    logic       tx;
    logic       busy;
    logic       overrun;
    logic [7:0] tx_count;

    reg_out_tx #(.CLKS_PER_BIT(CPB)) dut (
        .clock    (clock),
        .reset    (reset),
        .ena      (ena),
        .opcode   (opcode),
        .R0_in    (R0_in),
        .R1_in    (R1_in),
        .tx       (tx),
        .busy     (busy),
        .overrun  (overrun),
        .tx_count (tx_count)
    );

    always #5 clock = ~clock;

    int n_checks = 0;
    int n_pass   = 0;

    function automatic void check(input string name, input int act, input int exp);
        n_checks++;
        if (act == exp) n_pass++;
        else $display("FAIL %s: got %0d expected %0d at %0t", name, act, exp, $time);
    endfunction

    // Frame-level model: a frame is a start cycle plus a byte; the line value is
    // derived from elapsed time since the frame started.
    int         m_cyc    = 0;
    bit         m_active = 1'b0;
    int         m_start  = 0;
    logic [7:0] m_byte   = 8'h00;
    bit         m_pend   = 1'b0;
    logic [7:0] m_pbyte  = 8'h00;
    bit         m_ovr    = 1'b0;
    int         m_count  = 0;
    bit         cmp_en   = 1'b0;

    always @(posedge clock) begin
        bit         rq;
        logic [7:0] rb;
        m_cyc++;
        if (!reset) begin
            m_active = 1'b0;
            m_pend   = 1'b0;
            m_ovr    = 1'b0;
            m_count  = 0;
        end else begin
            rq = ena && (opcode == 3'd4 || opcode == 3'd5);
            rb = (opcode == 3'd5) ? R1_in : R0_in;
            if (m_active && (m_cyc - m_start == 10 * CPB)) begin
                m_count = (m_count + 1) % 256;
                if (m_pend) begin
                    m_start = m_cyc;
                    m_byte  = m_pbyte;
                    m_pend  = rq;
                    if (rq) m_pbyte = rb;
                end else if (rq) begin
                    m_start = m_cyc;
                    m_byte  = rb;
                end else begin
                    m_active = 1'b0;
                end
            end else if (m_active) begin
                if (rq) begin
                    if (!m_pend) begin
                        m_pend  = 1'b1;
                        m_pbyte = rb;
                    end else begin
                        m_ovr = 1'b1;
                    end
                end
            end else if (rq) begin
                m_active = 1'b1;
                m_start  = m_cyc;
                m_byte   = rb;
            end
        end
    end

    function automatic int exp_tx();
        int k;
        if (!m_active) return 1;
        k = (m_cyc - m_start) / CPB;
        if (k == 0) return 0;
        if (k <= 8) return int'(m_byte[k-1]);
        return 1;
    endfunction

    always @(negedge clock) begin
        if (cmp_en && reset) begin
            check("tx",       int'(tx),       exp_tx());
            check("busy",     int'(busy),     int'(m_active || m_pend));
            check("overrun",  int'(overrun),  int'(m_ovr));
            check("tx_count", int'(tx_count), m_count);
        end
    end

    task automatic step(input bit e, input logic [2:0] op, input logic [7:0] v);
        ena    = e;
        opcode = op;
        if (op == 3'd5) begin
            R1_in = v;
            R0_in = ~v;
        end else begin
            R0_in = v;
            R1_in = ~v;
        end
        @(posedge clock);
        #1;
        ena    = 1'b0;
        opcode = 3'd0;
        R0_in  = 8'($urandom);
        R1_in  = 8'($urandom);
    endtask

    task automatic idle(input int n);
        repeat (n) step(1'b0, 3'd0, 8'($urandom));
    endtask

    initial begin
        logic [9:0] fr;
        logic [7:0] dec;
        logic [2:0] ops [6];
        int         r;

        ops[0] = 3'd0; ops[1] = 3'd1; ops[2] = 3'd2;
        ops[3] = 3'd3; ops[4] = 3'd6; ops[5] = 3'd7;

        // Reset state
        repeat (3) @(posedge clock);
        #1;
        check("rst_tx", int'(tx), 1);
        check("rst_busy", int'(busy), 0);
        check("rst_overrun", int'(overrun), 0);
        check("rst_count", int'(tx_count), 0);
        reset  = 1'b1;
        cmp_en = 1'b1;
        idle(2);

        // Single OUT R0 of 0xA5: literal line pattern start,1,0,1,0,0,1,0,1,stop
        fr = 10'b1_1010_0101_0;
        step(1'b1, 3'd4, 8'hA5);
        for (int c = 0; c < 40; c++) begin
            check("a5_line", int'(tx), int'(fr[c / 4]));
            if (c == 39) check("a5_busy_before_end", int'(busy), 1);
            idle(1);
        end
        check("a5_busy_end", int'(busy), 0);
        check("a5_count", int'(tx_count), 1);

        // OUT R1 of 0x3C decoded at mid-bit
        dec = 8'h00;
        step(1'b1, 3'd5, 8'h3C);
        for (int c = 0; c < 40; c++) begin
            if (c == 2) check("3c_start", int'(tx), 0);
            if (c == 38) check("3c_stop", int'(tx), 1);
            if ((c % 4 == 2) && c >= 6 && c <= 34) dec[(c - 6) / 4] = tx;
            idle(1);
        end
        check("3c_decode", int'(dec), 8'h3C);
        check("3c_count", int'(tx_count), 2);

        // No request when ena=0 or for non-OUT opcodes
        step(1'b0, 3'd4, 8'h81);
        step(1'b0, 3'd5, 8'h81);
        for (int i = 0; i < 6; i++) step(1'b1, ops[i], 8'h81);
        idle(5);
        check("noreq_busy", int'(busy), 0);
        check("noreq_tx", int'(tx), 1);
        check("noreq_count", int'(tx_count), 2);

        // Buffer refill exactly at frame end: three contiguous frames, no overrun
        step(1'b1, 3'd4, 8'h11);
        idle(4);
        step(1'b1, 3'd4, 8'h22);
        idle(34);
        step(1'b1, 3'd4, 8'h44);
        check("refill_start2", int'(tx), 0);
        check("refill_ovr", int'(overrun), 0);
        idle(85);
        check("refill_count", int'(tx_count), 5);
        check("refill_ovr_end", int'(overrun), 0);
        check("refill_busy_end", int'(busy), 0);

        // Back-to-back with third request dropped
        step(1'b1, 3'd4, 8'h11);
        idle(4);
        step(1'b1, 3'd4, 8'h22);
        idle(3);
        step(1'b1, 3'd4, 8'h33);
        check("b2b_ovr", int'(overrun), 1);
        idle(30);
        check("b2b_stop", int'(tx), 1);
        idle(1);
        check("b2b_start2", int'(tx), 0);
        idle(40);
        check("b2b_count", int'(tx_count), 7);
        check("b2b_busy_end", int'(busy), 0);

        // Asynchronous reset during data bit 3
        step(1'b1, 3'd4, 8'h77);
        idle(17);
        reset = 1'b0;
        #1;
        check("mrst_tx", int'(tx), 1);
        check("mrst_busy", int'(busy), 0);
        check("mrst_ovr", int'(overrun), 0);
        check("mrst_count", int'(tx_count), 0);
        @(posedge clock);
        @(posedge clock);
        #1;
        reset = 1'b1;
        idle(1);
        step(1'b1, 3'd4, 8'h5A);
        idle(40);
        check("5a_count", int'(tx_count), 1);

        // 256 frames spaced one frame apart: count wraps through 255 to 0
        for (int j = 0; j < 256; j++) begin
            step(1'b1, 3'(4 + (j % 2)), 8'($urandom));
            if (j == 254) check("wrap_255", int'(tx_count), 255);
            if (j == 255) check("wrap_0", int'(tx_count), 0);
            idle(39);
        end
        idle(5);
        check("wrap_final", int'(tx_count), 1);
        check("wrap_ovr", int'(overrun), 0);

        // Randomized traffic, including bursts that provoke overruns
        for (int i = 0; i < 3000; i++) begin
            r = $urandom_range(0, 99);
            if (r < 8) step(1'b1, 3'($urandom_range(4, 5)), 8'($urandom));
            else if (r < 12) step(1'b1, 3'($urandom), 8'($urandom));
            else if (r < 14) step(1'b0, 3'($urandom_range(4, 5)), 8'($urandom));
            else idle(1);
        end
        idle(100);
        check("rand_idle_busy", int'(busy), 0);

        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

endmodule

// File: doc/reg_out_tx.md
Name: reg_out_tx

Overview:
Output-side consumer of the register file. It watches the decoded opcode stream for the OUT instructions: 3'b100 outputs R0 and 3'b101 outputs R1. On each OUT it captures the selected register value and transmits it as an 8N1 UART frame on a single serial line. A one-entry holding buffer absorbs one OUT issued while a frame is in flight. The block sits beside the register file and drives the UART pin of the FSM+UART stage.

Parameters:
CLKS_PER_BIT, 87, clock cycles per UART bit (10 MHz / 115200); legal range 2..65535

Ports:
clock  input  1  system clock, all state on rising edge
reset  input  1  asynchronous, active-low reset (0 = reset asserted)
ena  input  1  instruction-valid strobe; OUT decode and capture only when 1
opcode  input  3  decoded opcode; 3'b100 = OUT R0, 3'b101 = OUT R1, all others ignored
R0_in  input  8  current register R0 value
R1_in  input  8  current register R1 value
tx  output  1  UART serial out; idles high
busy  output  1  1 while a frame is in flight or the buffer holds a byte
overrun  output  1  sticky flag; set when an OUT request is dropped
tx_count  output  8  number of completed frames, modulo 256

Behaviour:
- Reset (reset=0, takes effect immediately, no clock needed):
  - tx=1, busy=0, overrun=0, tx_count=0
  - state=IDLE, buffer empty, bit/baud counters cleared
  - A frame in progress is aborted with no partial stop bit.
- Request:
  - Defined as ena=1 and opcode in {100,101}, sampled at a rising edge.
  - The byte is R0_in for 100 and R1_in for 101, sampled on that same edge.
  - ena=0 or any other opcode produces no request. Frames already in progress continue regardless of ena.
- FSM states:
  - IDLE: tx=1. A request at edge N loads the shift register and enters START at edge N, so tx=0 from edge N.
  - START: tx=0 for CLKS_PER_BIT cycles, then DATA.
  - DATA: 8 bits LSB first, each held CLKS_PER_BIT cycles. A 3-bit index goes 0..7; after bit 7, go to STOP.
  - STOP: tx=1 for CLKS_PER_BIT cycles.
  - Frame end is edge N+10*CLKS_PER_BIT. At that edge tx_count increments (255 wraps to 0), then:
    - If the buffer is full: load the buffered byte and enter START (back-to-back, no idle gap).
    - Else if a request arrives on that edge: load it and enter START.
    - Else: go to IDLE.
- Baud counter:
  - Counts 0..CLKS_PER_BIT-1 and clears on every state or bit change.
  - Width is the minimum needed to hold CLKS_PER_BIT-1.
- tx is driven from a register; there is no combinational path from inputs to tx.
- Buffer (1 entry):
  - Request while state!=IDLE and buffer empty: byte stored, buffer full.
  - Request while state!=IDLE and buffer full: request dropped and overrun set to 1. overrun stays 1 until reset; the buffered byte is unchanged.
  - Request on a frame-end edge while the buffer is full: the buffered byte starts transmitting and the new request is written into the buffer on the same edge. No drop, no overrun.
- busy = (state!=IDLE) | buffer_full, registered/consistent with state. busy=0 only when tx is idle-high with nothing pending.
- Frame spacing: consecutive frames start exactly 10*CLKS_PER_BIT cycles apart when back-to-back.

Test Plan:
- CLKS_PER_BIT=4; release reset; R0_in=8'hA5; opcode=100, ena=1 for 1 cycle -> tx=0 for 4 cycles, then 1,0,1,0,0,1,0,1 at 4 cycles each, stop=1 for 4 cycles; busy falls 40 cycles after the request edge; tx_count=1.
- R1_in=8'h3C; opcode=101, ena=1 -> serial byte decodes to 8'h3C. The same pulse with ena=0 -> tx stays 1, busy 0. Opcodes 000,001,010,011,110,111 with ena=1 -> no frame.
- Back-to-back: OUT R0 with 8'h11 at cycle 0, 8'h22 at cycle 5, 8'h33 at cycle 9 -> 8'h11 and 8'h22 sent contiguously (second start bit at cycle 40). 8'h33 is never sent; overrun=1 from cycle 9; tx_count=2.
- Buffer refill at frame end: 8'h11 at cycle 0, 8'h22 at cycle 5, 8'h44 exactly at cycle 40 -> three frames 8'h11, 8'h22, 8'h44 back-to-back; overrun stays 0.
- Mid-frame reset: pull reset=0 during data bit 3 -> tx=1, busy=0, overrun=0, tx_count=0 immediately, before the next clock. After release, OUT R0 with 8'h5A -> clean frame 8'h5A.
- Wrap: 256 consecutive single frames -> tx_count goes 255 then 0; overrun remains 0 throughout.
